// File: rtl/fir16_serial_mac.sv
// rtl/fir16_serial_mac.sv - serial 16-tap FIR multiply-accumulate with rounded Q1.15 output
// Build option FIR16_MAC_SAT_EN: saturate the output instead of two's-complement wrap.
module fir16_serial_mac #(
   parameter int NTAPS     = 16,
   parameter int DATA_W    = 16,
   parameter int ACC_W     = 36,
   parameter int FRAC_BITS = 15
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    start,
   input  logic [NTAPS*DATA_W-1:0] samples_flat,
   input  logic [NTAPS*DATA_W-1:0] coeffs_flat,
   output logic                    busy,
   output logic [DATA_W-1:0]       y_out,
   output logic                    y_valid
);

   localparam int IDX_W = $clog2(NTAPS);
   localparam int PROD_W = 2 * DATA_W;
   localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NTAPS - 1);
   localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1) << (FRAC_BITS - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_OUT  = 2'd2
   } state_t;

   state_t state_q, state_d;

   logic [NTAPS*DATA_W-1:0] snap_x, snap_h;
   logic [IDX_W-1:0]        idx;
   logic signed [ACC_W-1:0] acc;
   logic signed [DATA_W-1:0] x_sel, h_sel;
   logic signed [PROD_W-1:0] prod;
   logic signed [ACC_W-1:0] acc_rnd;
   logic [DATA_W-1:0]       y_next;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: if (start) state_d = S_MAC;
         S_MAC:  if (idx == IDX_LAST) state_d = S_OUT;
         S_OUT:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   assign busy = (state_q != S_IDLE);

   // One shared multiplier walks the frozen snapshot, tap idx per edge.
   assign x_sel = snap_x[idx*DATA_W +: DATA_W];
   assign h_sel = snap_h[idx*DATA_W +: DATA_W];
   assign prod  = x_sel * h_sel;

   assign acc_rnd = acc + RND_HALF;

`ifdef FIR16_MAC_SAT_EN
   logic signed [ACC_W-1:0]  r;
   logic [ACC_W-DATA_W:0]    r_top;
   logic                     r_in_range;

   assign r          = acc_rnd >>> FRAC_BITS;
   assign r_top      = r[ACC_W-1:DATA_W-1];
   // In range when every bit above the output sign bit matches it.
   assign r_in_range = (&r_top) | ~(|r_top);

   always_comb begin
      y_next = r[DATA_W-1:0];
      if (!r_in_range) begin
         y_next = r[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
      end
   end
`else
   assign y_next = DATA_W'(acc_rnd >>> FRAC_BITS);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         snap_x  <= '0;
         snap_h  <= '0;
         idx     <= '0;
         acc     <= '0;
         y_out   <= '0;
         y_valid <= 1'b0;
      end else begin
         y_valid <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  snap_x <= samples_flat;
                  snap_h <= coeffs_flat;
                  acc    <= '0;
                  idx    <= '0;
               end
            end
            S_MAC: begin
               acc <= acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
               idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            S_OUT: begin
               y_out   <= y_next;
               y_valid <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
